// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - cycle-budgeted run control with instruction trace FIFO
// Optional BREAK halt is compiled in with HALT_ON_BREAK_EN.
module cpu_run_ctrl #(
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 16,
    parameter int TRACE_DEPTH = 16
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             enable_i,
    input  logic                             start_i,
    input  logic [CNT_W-1:0]                 cycle_limit_i,
    input  logic [DATA_W-1:0]                instr_i,
    input  logic                             instr_valid_i,
    output logic                             cpu_enable_o,
    output logic                             running_o,
    output logic                             done_o,
    output logic                             halt_o,
    output logic [CNT_W-1:0]                 cycle_count_o,
    input  logic                             trace_rd_i,
    output logic [DATA_W-1:0]                trace_data_o,
    output logic                             trace_valid_o,
    output logic [$clog2(TRACE_DEPTH):0]     trace_count_o,
    output logic                             trace_overflow_o
);
    localparam int AW = $clog2(TRACE_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state, state_nx;

    logic [CNT_W-1:0]  limit_q, count_q, count_inc;
    logic [DATA_W-1:0] mem [TRACE_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       fill;
    logic              ovf_q;
    logic              start_ok, run_step, push, pop, full, do_push, brk;

    assign start_ok  = (state != S_RUN) && start_i && enable_i;
    assign run_step  = (state == S_RUN) && enable_i;
    assign push      = run_step && instr_valid_i;
    assign count_inc = count_q + CNT_W'(1);
    assign full      = (fill == (AW+1)'(TRACE_DEPTH));
    assign pop       = trace_rd_i && (fill != '0);
    // At full, a push only lands if the head leaves in the same cycle.
    assign do_push   = push && (!full || pop);

`ifdef HALT_ON_BREAK_EN
    logic halt_q;
    assign brk = push && (instr_i[31:26] == 6'h00) && (instr_i[5:0] == 6'h0D);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)       halt_q <= 1'b0;
        else if (start_ok) halt_q <= 1'b0;
        else if (brk)      halt_q <= 1'b1;
    end
    assign halt_o = halt_q;
`else
    assign brk    = 1'b0;
    assign halt_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_ok)
                    state_nx = (cycle_limit_i == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (run_step && ((count_inc == limit_q) || brk))
                    state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        running_o    = (state == S_RUN);
        done_o       = (state == S_DONE);
        cpu_enable_o = (state == S_RUN) && enable_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            limit_q <= '0;
            count_q <= '0;
        end else if (start_ok) begin
            limit_q <= cycle_limit_i;
            count_q <= '0;
        end else if (run_step) begin
            count_q <= count_inc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= instr_i;
    end

    // Start flush wins over a same-cycle pop.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            ovf_q  <= 1'b0;
        end else if (start_ok) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, pop})
                2'b10:   fill <= fill + (AW+1)'(1);
                2'b01:   fill <= fill - (AW+1)'(1);
                default: fill <= fill;
            endcase
            if (push && full && !pop) ovf_q <= 1'b1;
        end
    end

    assign cycle_count_o    = count_q;
    assign trace_valid_o    = (fill != '0);
    assign trace_count_o    = fill;
    assign trace_data_o     = (fill != '0) ? mem[rd_ptr] : '0;
    assign trace_overflow_o = ovf_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - directed and random checks of cpu_run_ctrl against a queue model
module tb_cpu_run_ctrl;
    localparam int DEPTH = 16;

    logic        clk_i = 1'b0;
    logic        reset_i, enable_i, start_i, instr_valid_i, trace_rd_i;
    logic [15:0] cycle_limit_i;
    logic [31:0] instr_i;
    logic        cpu_enable_o, running_o, done_o, halt_o, trace_valid_o, trace_overflow_o;
    logic [15:0] cycle_count_o;
    logic [31:0] trace_data_o;
    logic [4:0]  trace_count_o;

    cpu_run_ctrl dut (
        .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .start_i(start_i),
        .cycle_limit_i(cycle_limit_i), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
        .cpu_enable_o(cpu_enable_o), .running_o(running_o), .done_o(done_o), .halt_o(halt_o),
        .cycle_count_o(cycle_count_o), .trace_rd_i(trace_rd_i), .trace_data_o(trace_data_o),
        .trace_valid_o(trace_valid_o), .trace_count_o(trace_count_o),
        .trace_overflow_o(trace_overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_pass = 0;
    int n_total = 0;
    int en_hi = 0;

    // Model: phase 0 = idle, 1 = running, 2 = finished.
    int          m_phase, m_cnt, m_limit;
    bit          m_ovf, m_halt;
    logic [31:0] m_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_limit = 0; m_ovf = 0; m_halt = 0;
        m_q.delete();
    endtask

    task automatic model_step();
        bit p;
        p = trace_rd_i && (m_q.size() > 0);
        if (m_phase != 1 && start_i && enable_i) begin
            m_limit = cycle_limit_i;
            m_cnt = 0; m_ovf = 0; m_halt = 0;
            m_q.delete();
            m_phase = (cycle_limit_i == 0) ? 2 : 1;
        end else begin
            if (p) void'(m_q.pop_front());
            if (m_phase == 1 && enable_i) begin
                m_cnt = (m_cnt + 1) % 65536;
                if (instr_valid_i) begin
                    if (m_q.size() < DEPTH) m_q.push_back(instr_i);
                    else m_ovf = 1;
`ifdef HALT_ON_BREAK_EN
                    if (instr_i[31:26] == 6'h00 && instr_i[5:0] == 6'h0D) begin
                        m_halt = 1;
                        m_phase = 2;
                    end
`endif
                end
                if (m_cnt == m_limit) m_phase = 2;
            end
        end
    endtask

    task automatic compare_all();
        check("cpu_enable", cpu_enable_o, (m_phase == 1) && enable_i);
        check("running", running_o, m_phase == 1);
        check("done", done_o, m_phase == 2);
        check("halt", halt_o, m_halt);
        check("cycle_count", cycle_count_o, m_cnt);
        check("trace_count", trace_count_o, m_q.size());
        check("trace_valid", trace_valid_o, m_q.size() != 0);
        check("trace_data", trace_data_o, (m_q.size() != 0) ? m_q[0] : 32'h0);
        check("overflow", trace_overflow_o, m_ovf);
    endtask

    task automatic cyc(input logic st, input logic [15:0] lim, input logic en,
                       input logic v, input logic [31:0] ins, input logic rd);
        @(negedge clk_i);
        start_i = st; cycle_limit_i = lim; enable_i = en;
        instr_valid_i = v; instr_i = ins; trace_rd_i = rd;
        #1;
        compare_all();
        if (cpu_enable_o) en_hi++;
        @(posedge clk_i);
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        start_i = 0; enable_i = 0; instr_valid_i = 0; trace_rd_i = 0;
        reset_i = 1;
        model_reset();
        #1;
        compare_all();
        @(negedge clk_i);
        reset_i = 0;
    endtask

    initial begin
        reset_i = 1; enable_i = 0; start_i = 0; cycle_limit_i = 0;
        instr_i = 0; instr_valid_i = 0; trace_rd_i = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i); #1;
        compare_all();
        reset_i = 0;

        // limit 10, every cycle valid, then drain in order
        cyc(1, 10, 1, 0, 0, 0);
        en_hi = 0;
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 1, i, 0);
        #1;
        check("s1_en_cycles", en_hi, 10);
        check("s1_count", cycle_count_o, 10);
        check("s1_done", done_o, 1);
        check("s1_fill", trace_count_o, 10);
        for (int i = 0; i < 11; i++) cyc(0, 0, 1, 1, 32'hdead, 1);

        // limit 20 with a three-cycle pause
        do_reset();
        cyc(1, 20, 1, 0, 0, 0);
        en_hi = 0;
        for (int i = 0; i < 23; i++)
            cyc(0, 0, !(i >= 5 && i <= 7), 1, 32'h100 + i, 0);
        #1;
        check("s2_en_cycles", en_hi, 20);
        check("s2_count", cycle_count_o, 20);
        check("s2_done", done_o, 1);

        // overflow, then push+pop at full
        do_reset();
        cyc(1, 40, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, 1, 32'h200 + i, 0);
        #1;
        check("s3_fill_full", trace_count_o, 16);
        check("s3_overflow", trace_overflow_o, 1);
        check("s3_head", trace_data_o, 32'h200);
        cyc(0, 0, 1, 1, 32'h999, 1);
        #1;
        check("s3_fill_pushpop", trace_count_o, 16);
        check("s3_overflow_kept", trace_overflow_o, 1);
        for (int i = 0; i < 17; i++) cyc(0, 0, 0, 0, 0, 1);

        // limit 0
        do_reset();
        en_hi = 0;
        cyc(1, 0, 1, 1, 5, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 6, 0);
        #1;
        check("s4_en_cycles", en_hi, 0);
        check("s4_count", cycle_count_o, 0);
        check("s4_done", done_o, 1);

        // async reset mid-run at count 4, then restart
        do_reset();
        cyc(1, 30, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 32'h300 + i, 0);
        @(negedge clk_i);
        check("s5_count_before", cycle_count_o, 4);
        #2;
        reset_i = 1;
        model_reset();
        #1;
        compare_all();
        @(negedge clk_i);
        reset_i = 0;
        cyc(1, 3, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 32'h400 + i, 0);
        #1;
        check("s5_restart_count", cycle_count_o, 3);

`ifdef HALT_ON_BREAK_EN
        do_reset();
        cyc(1, 100, 1, 0, 0, 0);
        for (int i = 1; i <= 8; i++)
            cyc(0, 0, 1, 1, (i == 6) ? 32'h0000_000D : 32'h500 + i, 0);
        #1;
        check("s6_count", cycle_count_o, 6);
        check("s6_halt", halt_o, 1);
        check("s6_fill", trace_count_o, 6);
`endif

        // random traffic
        do_reset();
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 9) == 0, 16'($urandom_range(0, 24)),
                $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0,
                $urandom, $urandom_range(0, 2) == 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
